// File: rtl/srl_delay_line.sv
// Clock-enabled shift-register delay line with a runtime tap, a fixed cascade output
// and a saturating fill counter.
module srl_delay_line #(
  parameter int unsigned     WIDTH  = 1,
  parameter int unsigned     DEPTH  = 32,
  parameter int unsigned     ADDR_W = 5,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ce,
  input  logic [WIDTH-1:0]           d,
  input  logic [ADDR_W-1:0]          a,
  output logic [WIDTH-1:0]           q,
  output logic [WIDTH-1:0]           q_last,
  output logic                       filled,
  output logic [$clog2(DEPTH+1)-1:0] fill_count
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [CntW-1:0]  fill_q;
  logic [CntW-1:0]  fill_d;

  always_comb begin
    fill_d = fill_q;
    if (fill_q != CntW'(DEPTH)) begin
      fill_d = fill_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_q[i] <= INIT;
      end
      fill_q <= '0;
    end else if (ce) begin
      stage_q[0] <= d;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
      fill_q <= fill_d;
    end
  end

  // Out-of-range addresses fall through to the last stage, so q never goes X.
  always_comb begin
    q = stage_q[DEPTH-1];
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (a == ADDR_W'(i)) begin
        q = stage_q[i];
      end
    end
  end

  assign q_last     = stage_q[DEPTH-1];
  assign fill_count = fill_q;
  assign filled     = (fill_q == CntW'(DEPTH));

endmodule

// File: tb/tb_srl_delay_line.sv
// Directed bench: a 32x8 line with INIT=0 and a 5x8 line with nonzero INIT share stimulus.
module tb_srl_delay_line;

  logic       clk = 1'b0;
  logic       reset;
  logic       ce;
  logic [7:0] d;
  logic [4:0] a0;
  logic [2:0] a1;

  logic [7:0] q0, q0_last, q1, q1_last;
  logic       filled0, filled1;
  logic [5:0] cnt0;
  logic [2:0] cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  srl_delay_line #(.WIDTH(8), .DEPTH(32), .ADDR_W(5), .INIT(8'h00)) u_long (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .d          (d),
    .a          (a0),
    .q          (q0),
    .q_last     (q0_last),
    .filled     (filled0),
    .fill_count (cnt0)
  );

  srl_delay_line #(.WIDTH(8), .DEPTH(5), .ADDR_W(3), .INIT(8'h5A)) u_short (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .d          (d),
    .a          (a1),
    .q          (q1),
    .q_last     (q1_last),
    .filled     (filled1),
    .fill_count (cnt1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset behaviour: two reset cycles then one idle cycle, d=1 ce=0 a=7.
    reset = 1'b1; ce = 1'b0; d = 8'h01; a0 = 5'd7; a1 = 3'd7;
    for (int n = 0; n < 3; n++) begin
      if (n == 2) reset = 1'b0;
      tick();
      check("rst_q", 32'(q0), 32'h00);
      check("rst_q_last", 32'(q0_last), 32'h00);
      check("rst_filled", 32'(filled0), 32'h0);
      check("rst_count", 32'(cnt0), 32'h0);
      check("rst_init_q", 32'(q1), 32'h5A);
      check("rst_init_last", 32'(q1_last), 32'h5A);
      check("rst_init_count", 32'(cnt1), 32'h0);
    end

    // Single pulse through tap 15 and the cascade output.
    a0 = 5'd15; a1 = 3'd7; d = 8'h01; ce = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      d = 8'h00;
      check("pulse_q", 32'(q0), (n == 16) ? 32'h01 : 32'h00);
      check("pulse_q_last", 32'(q0_last), (n == 32) ? 32'h01 : 32'h00);
      check("pulse_count", 32'(cnt0), (n < 32) ? 32'(n) : 32'd32);
      check("short_clamp_q", 32'(q1), (n < 5) ? 32'h5A : ((n == 5) ? 32'h01 : 32'h00));
      check("short_filled", 32'(filled1), (n >= 5) ? 32'h1 : 32'h0);
    end

    // Reset-done generator: constant 1 shifted in.
    reset = 1'b1; tick(); reset = 1'b0;
    d = 8'h01; ce = 1'b1;
    for (int n = 1; n <= 35; n++) begin
      tick();
      check("done_q_last", 32'(q0_last), (n >= 32) ? 32'h01 : 32'h00);
      check("done_filled", 32'(filled0), (n >= 32) ? 32'h1 : 32'h0);
      check("done_count", 32'(cnt0), (n < 32) ? 32'(n) : 32'd32);
    end

    // Clock-enable gap at tap 0.
    a0 = 5'd0; d = 8'h00; tick();
    check("gate_pre", 32'(q0), 32'h00);
    d = 8'h01; tick();
    check("gate_cap", 32'(q0), 32'h01);
    ce = 1'b0; d = 8'h00;
    for (int n = 0; n < 5; n++) begin
      tick();
      check("gate_hold", 32'(q0), 32'h01);
      check("gate_count", 32'(cnt0), 32'd32);
    end
    ce = 1'b1; tick();
    check("gate_drop", 32'(q0), 32'h00);

    // Dynamic tap sweep over a ramp.
    reset = 1'b1; tick(); reset = 1'b0;
    for (int v = 0; v < 32; v++) begin
      d = 8'(v);
      tick();
    end
    ce = 1'b0;
    for (int i = 0; i < 32; i++) begin
      a0 = 5'(i);
      #1;
      check("sweep_q", 32'(q0), 32'(8'h1F - 8'(i)));
    end
    for (int i = 0; i < 8; i++) begin
      a1 = 3'(i);
      #1;
      check("short_sweep_q", 32'(q1), 32'(8'h1F - 8'((i < 4) ? i : 4)));
    end

    // Mid-stream reset, with ce also high on the reset edge.
    a0 = 5'd0; ce = 1'b1; d = 8'hAA;
    for (int n = 0; n < 10; n++) tick();
    check("mid_pre_q", 32'(q0), 32'hAA);
    reset = 1'b1; d = 8'h55; tick(); reset = 1'b0;
    check("mid_count", 32'(cnt0), 32'h0);
    check("mid_filled", 32'(filled1), 32'h0);
    check("mid_q_last", 32'(q1_last), 32'h5A);
    ce = 1'b0;
    for (int i = 0; i < 32; i++) begin
      a0 = 5'(i);
      #1;
      check("mid_taps", 32'(q0), 32'h00);
    end
    ce = 1'b1; d = 8'h33; a0 = 5'd0; a1 = 3'd1; tick();
    check("resume_count", 32'(cnt0), 32'd1);
    check("resume_q0", 32'(q0), 32'h33);
    check("resume_short_q1", 32'(q1), 32'h5A);
    a0 = 5'd1; #1;
    check("resume_q1", 32'(q0), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
